// File: rtl/variable_roundsat_pkg.sv
// Shared definitions for the variable round-and-saturate output stage.
package variable_roundsat_pkg;

  // Width of one SHIFT_TABLE entry (LSB-drop amount per mode)
  localparam int SHIFT_W  = 6;
  // Width of the saturation event counter
  localparam int SATCNT_W = 16;

  // Encoding 3 is reserved and behaves as truncation
  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALFUP    = 2'd1,
    RND_CONV      = 2'd2,
    RND_TRUNC_ALT = 2'd3
  } rnd_mode_e;

endpackage

// File: rtl/variable_roundsat_if.sv
// Streaming, mode-select and status signals of the round/saturate stage.
interface variable_roundsat_if
  import variable_roundsat_pkg::*;
#(
  parameter int IN_W  = 35,
  parameter int OUT_W = 12
);
  logic [2:0]          sel;
  logic [1:0]          rnd;
  logic [IN_W-1:0]     ast_sink_data;
  logic [1:0]          ast_sink_error;
  logic                ast_sink_valid;
  logic                ast_sink_ready;
  logic [OUT_W-1:0]    ast_source_data;
  logic [1:0]          ast_source_error;
  logic                ast_source_sat;
  logic                ast_source_valid;
  logic                ast_source_ready;
  logic                sat_clr;
  logic [SATCNT_W-1:0] sat_count;

  modport slave (
    input  sel, rnd, ast_sink_data, ast_sink_error, ast_sink_valid,
           ast_source_ready, sat_clr,
    output ast_sink_ready, ast_source_data, ast_source_error, ast_source_sat,
           ast_source_valid, sat_count
  );

  modport master (
    output sel, rnd, ast_sink_data, ast_sink_error, ast_sink_valid,
           ast_source_ready, sat_clr,
    input  ast_sink_ready, ast_source_data, ast_source_error, ast_source_sat,
           ast_source_valid, sat_count
  );
endinterface

// File: rtl/variable_roundsat_core.sv
// Two-stage round (stage 1) and shift/saturate (stage 2) datapath.
// Both stages advance only when en is high.
module roundsat_core
  import variable_roundsat_pkg::*;
#(
  parameter int IN_W      = 35,
  parameter int OUT_W     = 12,
  parameter bit SYMMETRIC = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  rnd_mode_e          in_rnd,
  input  logic [1:0]         in_error,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic [1:0]         out_error,
  output logic               out_sat
);

  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] ONE_V = 1;
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] MIN_V = SYMMETRIC ? -MAX_V : -MAX_V - ONE_V;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] half;
  logic signed [EXT_W-1:0] round_add;
  logic signed [EXT_W-1:0] s1_sum;
  logic [SHIFT_W-1:0]      s1_shift;
  logic [1:0]              s1_error;
  logic                    s1_valid;
  logic signed [EXT_W-1:0] shifted;
  logic [OUT_W-1:0]        data_next;
  logic                    sat_next;

  // Rounding increment; a zero shift never rounds
  always_comb begin
    ext       = {in_data[IN_W-1], in_data};
    half      = '0;
    round_add = '0;
    if (in_shift != '0) half = ONE_V <<< (in_shift - 1'b1);
    case (in_rnd)
      RND_HALFUP: round_add = half;
      RND_CONV:   if (in_shift != '0) round_add = half - ONE_V + (ext[in_shift] ? ONE_V : '0);
      default:    round_add = '0;
    endcase
  end

  // Stage 1 register: rounded sum plus the shift/error that travel with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
      s1_error <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sum   <= ext + round_add;
      s1_shift <= in_shift;
      s1_error <= in_error;
    end
  end

  // Arithmetic shift then clamp to the output range
  always_comb begin
    shifted   = s1_sum >>> s1_shift;
    sat_next  = 1'b0;
    data_next = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      data_next = MAX_V[OUT_W-1:0];
      sat_next  = 1'b1;
    end else if (shifted < MIN_V) begin
      data_next = MIN_V[OUT_W-1:0];
      sat_next  = 1'b1;
    end
  end

  // Stage 2 register drives the output beat directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_error <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_data  <= data_next;
      out_error <= s1_error;
      out_sat   <= sat_next;
    end
  end

endmodule

// File: rtl/variable_roundsat.sv
// Run-time selectable round/saturate stage with global-stall backpressure
// and a saturating count of clipped output beats.
module variable_roundsat
  import variable_roundsat_pkg::*;
#(
  parameter int                          IN_W        = 35,
  parameter int                          OUT_W       = 12,
  parameter int                          NUM_MODES   = 4,
  parameter logic [NUM_MODES*SHIFT_W-1:0] SHIFT_TABLE = {6'd13, 6'd16, 6'd19, 6'd14},
  parameter bit                          SYMMETRIC   = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  variable_roundsat_if.slave bus
);

  logic               stall;
  logic               accept;
  logic [SHIFT_W-1:0] shift_sel;

  // One stall for both stages; ready never depends on sink_valid
  assign stall              = bus.ast_source_valid && !bus.ast_source_ready;
  assign bus.ast_sink_ready = !stall;
  assign accept             = bus.ast_sink_valid && !stall;

  // Mode table lookup; out-of-range selects fall back to mode 0
  always_comb begin
    shift_sel = SHIFT_TABLE[SHIFT_W-1:0];
    for (int m = 0; m < NUM_MODES; m++) begin
      if (bus.sel == 3'(m)) shift_sel = SHIFT_TABLE[m*SHIFT_W +: SHIFT_W];
    end
  end

  roundsat_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .SYMMETRIC(SYMMETRIC)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (!stall),
    .in_valid (accept),
    .in_data  (bus.ast_sink_data),
    .in_shift (shift_sel),
    .in_rnd   (rnd_mode_e'(bus.rnd)),
    .in_error (bus.ast_sink_error),
    .out_valid(bus.ast_source_valid),
    .out_data (bus.ast_source_data),
    .out_error(bus.ast_source_error),
    .out_sat  (bus.ast_source_sat)
  );

  // Saturation counter: clear beats a coincident increment, sticks at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sat_count <= '0;
    end else if (bus.sat_clr) begin
      bus.sat_count <= '0;
    end else if (bus.ast_source_valid && bus.ast_source_ready &&
                 bus.ast_source_sat && (bus.sat_count != '1)) begin
      bus.sat_count <= bus.sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_variable_roundsat.sv
// Bench for variable_roundsat: vector table, random backpressure against a
// reference model, mid-stream reset and post-reset latency.
module tb_variable_roundsat;
  import variable_roundsat_pkg::*;

  typedef struct {
    logic [34:0] din;
    logic [2:0]  sel;
    logic [1:0]  rnd;
    logic [1:0]  err;
    logic [11:0] exp_d;
    logic        exp_sat;
    logic [11:0] exp_ds;
    logic        exp_sats;
  } vec_t;

  typedef struct {
    logic [11:0] data;
    logic        sat;
    logic [11:0] data_s;
    logic        sat_s;
    logic [1:0]  err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   bp_en = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vt[21];

  always #5 clk = ~clk;

  variable_roundsat_if #(.IN_W(35), .OUT_W(12)) bus ();
  variable_roundsat_if #(.IN_W(35), .OUT_W(12)) bus_s ();

  variable_roundsat dut (.clk(clk), .reset(reset), .bus(bus.slave));
  variable_roundsat #(.SYMMETRIC(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bus_s.slave));

  assign bus_s.sel              = bus.sel;
  assign bus_s.rnd              = bus.rnd;
  assign bus_s.ast_sink_data    = bus.ast_sink_data;
  assign bus_s.ast_sink_error   = bus.ast_sink_error;
  assign bus_s.ast_sink_valid   = bus.ast_sink_valid;
  assign bus_s.ast_source_ready = bus.ast_source_ready;
  assign bus_s.sat_clr          = bus.sat_clr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [12:0] model(input logic [34:0] d, input logic [2:0] sel,
                                        input logic [1:0] rnd, input bit sym);
    int s;
    longint v, q, r, half, lo;
    case (sel)
      3'd1:    s = 19;
      3'd2:    s = 16;
      3'd3:    s = 13;
      default: s = 14;
    endcase
    v    = longint'($signed(d));
    q    = v >>> s;
    r    = v - (q <<< s);
    half = longint'(1) <<< (s - 1);
    if (rnd == 2'd1 && r >= half) q++;
    if (rnd == 2'd2 && (r > half || (r == half && q[0]))) q++;
    lo = sym ? -2047 : -2048;
    if (q > 2047) return {1'b1, 12'h7FF};
    if (q < lo) return {1'b1, 12'(lo)};
    return {1'b0, 12'(q)};
  endfunction

  function automatic exp_t mk_exp(input logic [34:0] d, input logic [2:0] sel,
                                  input logic [1:0] rnd, input logic [1:0] err);
    exp_t x;
    {x.sat, x.data}     = model(d, sel, rnd, 1'b0);
    {x.sat_s, x.data_s} = model(d, sel, rnd, 1'b1);
    x.err = err;
    return x;
  endfunction

  // Drive one beat; returns just after the edge that accepts it
  task automatic send(input logic [34:0] d, input logic [2:0] sel, input logic [1:0] rnd,
                      input logic [1:0] err, input exp_t x);
    bit ok;
    bus.ast_sink_data  = d;
    bus.sel            = sel;
    bus.rnd            = rnd;
    bus.ast_sink_error = err;
    bus.ast_sink_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ast_sink_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    else sb.push_back(x);
    @(posedge clk);
    #1;
    bus.ast_sink_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    chk("drain_left", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Random or always-high downstream ready, changed just after each edge
  always @(posedge clk) begin
    #1;
    bus.ast_source_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard pop, stall stability, ready rule, counter model
  logic [15:0] cnt_m, cnt_ms;
  bit          prev_stall;
  logic [11:0] prev_d, prev_ds;
  logic [1:0]  prev_e;
  logic        prev_sat;
  exp_t        e;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      cnt_m      = '0;
      cnt_ms     = '0;
    end else begin
      chk("sink_ready", 64'(bus.ast_sink_ready),
          64'(!(bus.ast_source_valid && !bus.ast_source_ready)));
      chk("sat_count", 64'(bus.sat_count), 64'(cnt_m));
      chk("sat_count_sym", 64'(bus_s.sat_count), 64'(cnt_ms));
      if (prev_stall) begin
        chk("stall_data", 64'(bus.ast_source_data), 64'(prev_d));
        chk("stall_err", 64'(bus.ast_source_error), 64'(prev_e));
        chk("stall_sat", 64'(bus.ast_source_sat), 64'(prev_sat));
        chk("stall_data_sym", 64'(bus_s.ast_source_data), 64'(prev_ds));
      end
      if (bus.ast_source_valid && bus.ast_source_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'(0), 64'(1));
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(bus.ast_source_data), 64'(e.data));
          chk("out_err", 64'(bus.ast_source_error), 64'(e.err));
          chk("out_sat", 64'(bus.ast_source_sat), 64'(e.sat));
          chk("sym_valid", 64'(bus_s.ast_source_valid), 64'(1));
          chk("sym_data", 64'(bus_s.ast_source_data), 64'(e.data_s));
          chk("sym_sat", 64'(bus_s.ast_source_sat), 64'(e.sat_s));
          if (!bus.sat_clr) begin
            if (e.sat && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            if (e.sat_s && cnt_ms != 16'hFFFF) cnt_ms = cnt_ms + 16'd1;
          end
        end
      end
      if (bus.sat_clr) begin
        cnt_m  = '0;
        cnt_ms = '0;
      end
      prev_stall = bus.ast_source_valid && !bus.ast_source_ready;
      prev_d     = bus.ast_source_data;
      prev_ds    = bus_s.ast_source_data;
      prev_e     = bus.ast_source_error;
      prev_sat   = bus.ast_source_sat;
    end
  end

  initial begin
    int   n_sat, n_sats;
    logic [34:0] d;
    logic [2:0]  s;
    logic [1:0]  r, er;
    exp_t x;

    //        din              sel   rnd   err   exp    sat   exp_sym sat_sym
    vt[0]  = '{35'd16384,      3'd0, 2'd0, 2'd0, 12'h001, 1'b0, 12'h001, 1'b0};
    vt[1]  = '{35'd8192,       3'd0, 2'd0, 2'd1, 12'h000, 1'b0, 12'h000, 1'b0};
    vt[2]  = '{35'd8192,       3'd0, 2'd1, 2'd2, 12'h001, 1'b0, 12'h001, 1'b0};
    vt[3]  = '{35'd8192,       3'd0, 2'd2, 2'd3, 12'h000, 1'b0, 12'h000, 1'b0};
    vt[4]  = '{35'd24576,      3'd0, 2'd2, 2'd0, 12'h002, 1'b0, 12'h002, 1'b0};
    vt[5]  = '{35'd40960,      3'd0, 2'd2, 2'd1, 12'h002, 1'b0, 12'h002, 1'b0};
    vt[6]  = '{-35'sd8192,     3'd0, 2'd2, 2'd2, 12'h000, 1'b0, 12'h000, 1'b0};
    vt[7]  = '{-35'sd24576,    3'd0, 2'd2, 2'd3, 12'hFFE, 1'b0, 12'hFFE, 1'b0};
    vt[8]  = '{35'd33554432,   3'd0, 2'd0, 2'd3, 12'h7FF, 1'b1, 12'h7FF, 1'b1};
    vt[9]  = '{-35'sd33570816, 3'd0, 2'd0, 2'd1, 12'h800, 1'b1, 12'h801, 1'b1};
    vt[10] = '{-35'sd33554432, 3'd0, 2'd0, 2'd2, 12'h800, 1'b0, 12'h801, 1'b1};
    vt[11] = '{35'd33538048,   3'd0, 2'd0, 2'd0, 12'h7FF, 1'b0, 12'h7FF, 1'b0};
    vt[12] = '{35'd33546240,   3'd0, 2'd1, 2'd1, 12'h7FF, 1'b1, 12'h7FF, 1'b1};
    vt[13] = '{35'd524288,     3'd0, 2'd0, 2'd0, 12'h020, 1'b0, 12'h020, 1'b0};
    vt[14] = '{35'd524288,     3'd1, 2'd0, 2'd1, 12'h001, 1'b0, 12'h001, 1'b0};
    vt[15] = '{35'd524288,     3'd2, 2'd0, 2'd2, 12'h008, 1'b0, 12'h008, 1'b0};
    vt[16] = '{35'd524288,     3'd3, 2'd0, 2'd3, 12'h040, 1'b0, 12'h040, 1'b0};
    vt[17] = '{35'd524288,     3'd5, 2'd0, 2'd0, 12'h020, 1'b0, 12'h020, 1'b0};
    vt[18] = '{35'd8192,       3'd0, 2'd3, 2'd1, 12'h000, 1'b0, 12'h000, 1'b0};
    vt[19] = '{35'd786432,     3'd1, 2'd2, 2'd2, 12'h002, 1'b0, 12'h002, 1'b0};
    vt[20] = '{35'd786432,     3'd3, 2'd0, 2'd3, 12'h060, 1'b0, 12'h060, 1'b0};

    bus.ast_sink_valid = 1'b0;
    bus.ast_sink_data  = '0;
    bus.ast_sink_error = '0;
    bus.sel            = '0;
    bus.rnd            = '0;
    bus.sat_clr        = 1'b0;

    #1;
    chk("rst_valid", 64'(bus.ast_source_valid), 64'(0));
    chk("rst_data", 64'(bus.ast_source_data), 64'(0));
    chk("rst_sat", 64'(bus.ast_source_sat), 64'(0));
    chk("rst_count", 64'(bus.sat_count), 64'(0));
    chk("rst_ready", 64'(bus.ast_sink_ready), 64'(1));
    #22;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors, back-to-back with ready high
    n_sat  = 0;
    n_sats = 0;
    foreach (vt[i]) begin
      x = '{data: vt[i].exp_d, sat: vt[i].exp_sat, data_s: vt[i].exp_ds,
            sat_s: vt[i].exp_sats, err: vt[i].err};
      if (vt[i].exp_sat) n_sat++;
      if (vt[i].exp_sats) n_sats++;
      send(vt[i].din, vt[i].sel, vt[i].rnd, vt[i].err, x);
    end
    drain();
    chk("tbl_sat_count", 64'(bus.sat_count), 64'(n_sat));
    chk("tbl_sat_count_sym", 64'(bus_s.sat_count), 64'(n_sats));
    bus.sat_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.sat_clr = 1'b0;
    chk("sat_clr", 64'(bus.sat_count), 64'(0));

    // Continuous source against random backpressure and random clears
    bp_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      d  = 35'({$urandom, $urandom});
      d  = 35'($signed(d) >>> $urandom_range(0, 22));
      s  = 3'($urandom_range(0, 7));
      r  = 2'($urandom_range(0, 3));
      er = 2'($urandom_range(0, 3));
      bus.sat_clr = ($urandom_range(0, 9) == 0);
      send(d, s, r, er, mk_exp(d, s, r, er));
    end
    bus.sat_clr = 1'b0;
    bp_en = 1'b0;
    drain();

    // Mid-stream reset with two beats in flight
    send(35'd33554432, 3'd0, 2'd0, 2'd3, mk_exp(35'd33554432, 3'd0, 2'd0, 2'd3));
    send(35'd16384, 3'd0, 2'd0, 2'd1, mk_exp(35'd16384, 3'd0, 2'd0, 2'd1));
    chk("pre_rst_valid", 64'(bus.ast_source_valid), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("arst_valid", 64'(bus.ast_source_valid), 64'(0));
    chk("arst_data", 64'(bus.ast_source_data), 64'(0));
    chk("arst_err", 64'(bus.ast_source_error), 64'(0));
    chk("arst_sat", 64'(bus.ast_source_sat), 64'(0));
    chk("arst_count", 64'(bus.sat_count), 64'(0));
    chk("arst_ready", 64'(bus.ast_sink_ready), 64'(1));
    chk("arst_valid_sym", 64'(bus_s.ast_source_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 64'(bus.ast_source_valid), 64'(0));
    chk("rst_hold_ready", 64'(bus.ast_sink_ready), 64'(1));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // First beat after reset: valid two cycles after accept, error aligned
    send(35'd16384, 3'd0, 2'd0, 2'd3, mk_exp(35'd16384, 3'd0, 2'd0, 2'd3));
    chk("lat_cycle1_valid", 64'(bus.ast_source_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("lat_cycle2_valid", 64'(bus.ast_source_valid), 64'(1));
    chk("lat_data", 64'(bus.ast_source_data), 64'(1));
    chk("lat_err", 64'(bus.ast_source_error), 64'(3));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
